mem_byte_loader: RTL and testbench

- Boot-time loader sitting directly upstream of the 8x16 data memory.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs (high byte first) into 16-bit words.
- Writes the words into consecutive memory rows 0..WORDS-1 using the memory's cs/we/addr/din port.
- Passes the CPU's memory port through to the memory whenever it is not loading.

---
 rtl/mem_byte_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_byte_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_loader
// Description : Boot-time loader placed directly in front of the 8x16 data
//               memory. Bytes arriving on a valid/ready stream are packed in
//               pairs (high byte first) into 16-bit words. The words are
//               written into memory rows 0..WORDS-1 through the memory's
//               cs/we/addr/din port. When no load is running, the CPU's
//               memory port passes straight through to the memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORDS       rows written per load sequence, legal range 1..7
//               (row 7 is not mapped in the memory)
// Optional feature macro
//   LOADER_CHECKSUM_EN  defined  : checksum holds the 16-bit sum of the
//                                  words written by the current/last load
//                       undefined: checksum is tied to zero, no adder built
// Ports
//   clk         in   1   system clock, rising-edge active
//   rst         in   1   synchronous active-high reset (also resets memory)
//   load_start  in   1   single-cycle request to start a load sequence
//   in_byte     in   8   stream byte
//   in_valid    in   1   in_byte is valid
//   in_ready    out  1   loader accepts a byte this cycle
//   cpu_cs      in   1   CPU memory chip select
//   cpu_we      in   1   CPU memory write enable
//   cpu_addr    in   3   CPU memory address
//   cpu_din     in   16  CPU write data
//   mem_cs      out  1   memory chip select
//   mem_we      out  1   memory write enable
//   mem_addr    out  3   memory address
//   mem_din     out  16  memory write data
//   busy        out  1   load in progress, CPU port locked out
//   done        out  1   one-cycle pulse after the last word is written
//   checksum    out  16  running word sum (zero when feature disabled)
// ============================================================================
module mem_byte_loader #(
    parameter int WORDS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_addr,
    input  logic [15:0] cpu_din,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [2:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_GET_HI = 3'd1;
    localparam logic [2:0] c_S_GET_LO = 3'd2;
    localparam logic [2:0] c_S_SETUP  = 3'd3;
    localparam logic [2:0] c_S_WRITE  = 3'd4;
    localparam logic [2:0] c_S_HOLD   = 3'd5;
    localparam logic [2:0] c_S_DONE   = 3'd6;

    // Index of the final row written by a load sequence.
    localparam logic [2:0] c_LAST_PTR = 3'(WORDS - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [2:0]  r_ptr;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;

    logic        w_ready;
    logic        w_busy;
    logic        w_done;
    logic        w_ld_cs;
    logic        w_ld_we;
    logic        w_start;
    logic        w_last;

    // A start request only counts while idle; a request during a load is
    // simply dropped.
    assign w_start = (r_state == c_S_IDLE) && load_start;
    assign w_last  = (r_ptr == c_LAST_PTR);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and loader-side drive decode. Everything here is a function
    // of the state registers (plus in_valid/load_start for the next state
    // only), so no path exists from in_byte to the memory port.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_ld_cs     = 1'b0;
        w_ld_we     = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_busy = 1'b0;
                if (load_start) begin
                    w_state_nxt = c_S_GET_HI;
                end
            end

            c_S_GET_HI: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = c_S_GET_LO;
                end
            end

            c_S_GET_LO: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = c_S_SETUP;
                end
            end

            // SETUP/WRITE/HOLD keep addr/din stable around the single write
            // cycle so the memory's gated row clock sees settled data for a
            // full high phase.
            c_S_SETUP: begin
                w_ld_cs     = 1'b1;
                w_state_nxt = c_S_WRITE;
            end

            c_S_WRITE: begin
                w_ld_cs     = 1'b1;
                w_ld_we     = 1'b1;
                w_state_nxt = c_S_HOLD;
            end

            c_S_HOLD: begin
                w_ld_cs = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_S_DONE;
                end else begin
                    w_state_nxt = c_S_GET_HI;
                end
            end

            c_S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_S_IDLE;
            end

            default: begin
                w_busy      = 1'b0;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: row pointer and byte capture registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 3'd0;
            r_hi  <= 8'h00;
            r_lo  <= 8'h00;
        end else begin
            if (w_start) begin
                r_ptr <= 3'd0;
            end else if ((r_state == c_S_HOLD) && !w_last) begin
                r_ptr <= r_ptr + 3'd1;
            end

            if ((r_state == c_S_GET_HI) && in_valid) begin
                r_hi <= in_byte;
            end

            if ((r_state == c_S_GET_LO) && in_valid) begin
                r_lo <= in_byte;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional running checksum
    // ------------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Cleared when a new load leaves IDLE, accumulated once per word in the
    // WRITE cycle, and held after DONE until the next start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= 16'h0000;
        end else if (w_start) begin
            r_checksum <= 16'h0000;
        end else if (r_state == c_S_WRITE) begin
            r_checksum <= r_checksum + {r_hi, r_lo};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

    // ------------------------------------------------------------------------
    // Memory port mux: CPU owns the port whenever the loader is idle.
    // ------------------------------------------------------------------------
    assign in_ready = w_ready;
    assign busy     = w_busy;
    assign done     = w_done;

    assign mem_cs   = w_busy ? w_ld_cs       : cpu_cs;
    assign mem_we   = w_busy ? w_ld_we       : cpu_we;
    assign mem_addr = w_busy ? r_ptr         : cpu_addr;
    assign mem_din  = w_busy ? {r_hi, r_lo}  : cpu_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_loader
// Description : Directed self-checking bench for mem_byte_loader. A small
//               8x16 memory model sits on the mem_* port so that CPU
//               readback through the passthrough can be checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        cpu_cs = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_addr = 3'd0;
    logic [15:0] cpu_din = 16'h0000;
    logic        mem_cs;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_din;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int total = 0;
    int bad   = 0;

    mem_byte_loader #(.WORDS(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cpu_cs     (cpu_cs),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // 8x16 memory model, cleared by the shared reset; row 7 unmapped.
    // ------------------------------------------------------------------------
    logic [15:0] mem_model [0:7];
    int          addr7_writes = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 16'h0000;
        end else if (mem_cs === 1'b1 && mem_we === 1'b1) begin
            if (mem_addr == 3'd7) addr7_writes <= addr7_writes + 1;
            else                  mem_model[mem_addr] <= mem_din;
        end
    end

    // ------------------------------------------------------------------------
    // Observation monitor, sampled on the falling edge.
    // ------------------------------------------------------------------------
    int          tcyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_t = 0;
    int          start_t = 0;
    int          lock_viol = 0;
    int          ffff_viol = 0;
    int          cks_nz = 0;
    logic        prev_busy = 1'b0;
    logic [2:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];

    always @(negedge clk) begin
        tcyc      <= tcyc + 1;
        prev_busy <= busy;
        if (busy === 1'b1 && prev_busy !== 1'b1) start_t <= tcyc;
        if (busy === 1'b1 && mem_cs === 1'b1 && mem_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= mem_addr;
                wr_data[wr_cnt] <= mem_din;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_t   <= tcyc;
        end
        if (in_ready === 1'b1 && (mem_cs !== 1'b0 || mem_we !== 1'b0)) lock_viol <= lock_viol + 1;
        if (busy === 1'b1 && mem_cs === 1'b1 && mem_din === 16'hFFFF) ffff_viol <= ffff_viol + 1;
        if (checksum !== 16'h0000) cks_nz <= cks_nz + 1;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    logic [7:0] stream [0:15];
    int         stall_bad = 0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pulses load_start, then feeds stream[0..nbytes-1]. stall_len cycles of
    // in_valid=0 are inserted when the byte index reaches stall_at. A second
    // load_start is pulsed at loop cycle restart_at (negative: never). Stops
    // on done, on stop_writes loader writes (if >0), or at a cycle budget.
    task automatic run_load(input int nbytes, input int stall_at, input int stall_len,
                            input int stop_writes, input int restart_at,
                            output int wrote, output bit finished);
        int idx;
        int stall;
        int cyc;
        int w0;
        bit xfer;
        bit withhold;
        w0       = wr_cnt;
        idx      = 0;
        stall    = 0;
        cyc      = 0;
        finished = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        while (cyc < 300 && !finished) begin
            withhold = (idx == stall_at) && (stall < stall_len);
            if (idx < nbytes && !withhold) begin
                in_valid = 1'b1;
                in_byte  = stream[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (withhold) begin
                stall++;
                if (in_ready !== 1'b1 || mem_we !== 1'b0) stall_bad++;
            end
            load_start = (cyc == restart_at);
            xfer = in_valid && in_ready;
            step();
            cyc++;
            if (xfer) idx++;
            if (done === 1'b1) finished = 1'b1;
            if (stop_writes > 0 && (wr_cnt - w0) >= stop_writes) break;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        wrote = wr_cnt - w0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd3; cpu_din = 16'h0000;
        step();
        load_start = 1'b1;           // same cycle as reset: reset must win
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL reset_checksum: got %h want 0000", checksum); end
        total++; if (mem_cs !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_pass_cs_we: got %b%b want 10", mem_cs, mem_we); end
        total++; if (mem_addr !== 3'd3) begin bad++; $display("FAIL reset_pass_addr: got %0d want 3", mem_addr); end
        rst = 1'b0; load_start = 1'b0;
        // Bytes offered while idle are refused and do not start a load.
        in_valid = 1'b1; in_byte = 8'h55;
        step();
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_refuse: got ready=%b busy=%b want 0 0", in_ready, busy); end
        in_valid = 1'b0; cpu_cs = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [0:6];
        int w0, d0, wrote;
        bit fin;
        exp_w[0] = 16'h1234; exp_w[1] = 16'h5678; exp_w[2] = 16'h9ABC; exp_w[3] = 16'hDEF0;
        exp_w[4] = 16'h1122; exp_w[5] = 16'h3344; exp_w[6] = 16'h5566;
        stream[0]  = 8'h12; stream[1]  = 8'h34; stream[2]  = 8'h56; stream[3]  = 8'h78;
        stream[4]  = 8'h9A; stream[5]  = 8'hBC; stream[6]  = 8'hDE; stream[7]  = 8'hF0;
        stream[8]  = 8'h11; stream[9]  = 8'h22; stream[10] = 8'h33; stream[11] = 8'h44;
        stream[12] = 8'h55; stream[13] = 8'h66;
        w0 = wr_cnt; d0 = done_cnt;
        run_load(14, -1, 0, 0, -1, wrote, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL b2b_done_seen: got %b want 1", fin); end
        total++; if (wrote != 7) begin bad++; $display("FAIL b2b_write_count: got %0d want 7", wrote); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (wr_addr[w0 + i] !== 3'(i) || wr_data[w0 + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL b2b_write%0d: got addr=%0d din=%h want addr=%0d din=%h",
                         i, wr_addr[w0 + i], wr_data[w0 + i], i, exp_w[i]);
            end
        end
        total++; if (done_t - start_t != 35) begin bad++; $display("FAIL b2b_latency: got %0d want 35", done_t - start_t); end
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0;
        step();
        step();
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt - d0); end
        total++; if (busy !== 1'b0 || mem_model[mem_addr] !== 16'h1234) begin bad++; $display("FAIL b2b_readback0: got busy=%b data=%h want 0 1234", busy, mem_model[mem_addr]); end
        cpu_cs = 1'b0;
    endtask

    task automatic test_stall();
        int w0, sb0, wrote;
        bit fin;
        stream[0] = 8'hAB; stream[1] = 8'hCD;
        for (int i = 2; i < 14; i++) stream[i] = 8'(i - 1);
        w0 = wr_cnt; sb0 = stall_bad;
        run_load(14, 1, 4, 0, -1, wrote, fin);
        total++; if (fin !== 1'b1 || wrote != 7) begin bad++; $display("FAIL stall_complete: got done=%b writes=%0d want 1 7", fin, wrote); end
        total++; if (stall_bad != sb0) begin bad++; $display("FAIL stall_ready_hold: got %0d bad cycles want 0", stall_bad - sb0); end
        total++; if (wr_addr[w0] !== 3'd0 || wr_data[w0] !== 16'hABCD) begin bad++; $display("FAIL stall_row0_write: got addr=%0d din=%h want 0 ABCD", wr_addr[w0], wr_data[w0]); end
        total++; if (done_t - start_t != 39) begin bad++; $display("FAIL stall_latency: got %0d want 39", done_t - start_t); end
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0;
        step();
        total++; if (mem_model[mem_addr] !== 16'hABCD) begin bad++; $display("FAIL stall_readback0: got %h want ABCD", mem_model[mem_addr]); end
        cpu_cs = 1'b0;
    endtask

    task automatic test_lockout();
        int w0, lv0, fv0, a70, wrote;
        bit fin;
        for (int i = 0; i < 14; i++) stream[i] = 8'(i);
        w0 = wr_cnt; lv0 = lock_viol; fv0 = ffff_viol; a70 = addr7_writes;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd5; cpu_din = 16'hFFFF;
        run_load(14, -1, 0, 0, 12, wrote, fin);
        cpu_we = 1'b0;
        total++; if (fin !== 1'b1 || wrote != 7) begin bad++; $display("FAIL lock_complete: got done=%b writes=%0d want 1 7", fin, wrote); end
        total++; if (ffff_viol != fv0) begin bad++; $display("FAIL lock_cpu_leak: got %0d cycles want 0", ffff_viol - fv0); end
        total++; if (lock_viol != lv0) begin bad++; $display("FAIL lock_get_drive: got %0d cycles want 0", lock_viol - lv0); end
        total++; if (done_t - start_t != 35) begin bad++; $display("FAIL lock_restart_ignored: got latency %0d want 35", done_t - start_t); end
        total++; if (wr_data[w0 + 5] !== 16'h0A0B) begin bad++; $display("FAIL lock_row5_write: got %h want 0A0B", wr_data[w0 + 5]); end
        total++; if (addr7_writes != a70) begin bad++; $display("FAIL lock_addr7: got %0d writes want 0", addr7_writes - a70); end
        cpu_addr = 3'd5;
        step();
        total++; if (mem_model[mem_addr] !== 16'h0A0B) begin bad++; $display("FAIL lock_readback5: got %h want 0A0B", mem_model[mem_addr]); end
        cpu_cs = 1'b0; cpu_din = 16'h0000;
    endtask

    task automatic test_reset_mid();
        int wrote;
        bit fin;
        for (int i = 0; i < 14; i++) stream[i] = 8'(8'h21 + i);
        run_load(14, -1, 0, 3, -1, wrote, fin);
        total++; if (wrote != 3) begin bad++; $display("FAIL rmid_writes: got %0d want 3", wrote); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_idle: got busy=%b ready=%b done=%b want 0 0 0", busy, in_ready, done); end
        total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL rmid_checksum: got %h want 0000", checksum); end
        cpu_cs = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 3'(i);
            #1;
            total++;
            if (mem_addr !== 3'(i) || mem_model[mem_addr] !== 16'h0000) begin
                bad++;
                $display("FAIL rmid_row%0d: got addr=%0d data=%h want %0d 0000", i, mem_addr, mem_model[mem_addr], i);
            end
        end
        cpu_cs = 1'b0;
        step();
    endtask

    task automatic test_checksum();
        int wrote, cz0;
        bit fin;
        stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'h00; stream[3] = 8'h02;
        for (int i = 4; i < 14; i++) stream[i] = 8'h00;
        cz0 = cks_nz;
        run_load(14, -1, 0, 0, -1, wrote, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL cks_done_seen: got %b want 1", fin); end
`ifdef LOADER_CHECKSUM_EN
        total++; if (checksum !== 16'h0001) begin bad++; $display("FAIL cks_at_done: got %h want 0001", checksum); end
        step();
        step();
        total++; if (checksum !== 16'h0001) begin bad++; $display("FAIL cks_hold: got %h want 0001", checksum); end
`else
        total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL cks_at_done: got %h want 0000", checksum); end
        step();
        step();
        total++; if (cks_nz != cz0) begin bad++; $display("FAIL cks_tied_zero: got %0d nonzero cycles want 0", cks_nz - cz0); end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_lockout();
        test_reset_mid();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
